ms_neighbor_scan: RTL and testbench

//  Minesweeper board pre-processor. On start it snapshots the mine bitmap, then walks

---
 rtl/ms_neighbor_scan.sv | 104 ++++++++++
 tb/tb_ms_neighbor_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ms_neighbor_scan.sv
// Minesweeper board pre-processor: snapshots the mine bitmap on start, then streams
// every cell in row-major order with its 8-neighbour mine count over valid/ready.
module ms_neighbor_scan #(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int CB   = 4,
  parameter int RB   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] mines,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RB-1:0]        out_row,
  output logic [CB-1:0]        out_col,
  output logic [3:0]           out_cnt,
  output logic                 out_mine
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  logic [1:0]           state_reg;
  logic [RB-1:0]        row_reg;
  logic [CB-1:0]        col_reg;
  logic [ROWS*COLS-1:0] snapshot_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      col_reg      <= '0;
      snapshot_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            snapshot_reg <= mines;
            row_reg      <= '0;
            col_reg      <= '0;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (col_reg == CB'(COLS - 1)) begin
              col_reg <= '0;
              if (row_reg == RB'(ROWS - 1)) begin
                row_reg   <= '0;
                state_reg <= DONE;
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One tap per 3x3 window position; off-board taps and the centre contribute 0.
  logic [8:0] nb;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_nb
      localparam int DR = gi / 3 - 1;
      localparam int DC = gi % 3 - 1;
      logic          in_bounds;
      logic [IW-1:0] idx;
      assign in_bounds = (int'(row_reg) + DR >= 0) && (int'(row_reg) + DR < ROWS) &&
                         (int'(col_reg) + DC >= 0) && (int'(col_reg) + DC < COLS);
      assign idx = in_bounds ? IW'((int'(row_reg) + DR) * COLS + int'(col_reg) + DC) : '0;
      assign nb[gi] = (gi != 4) && in_bounds && snapshot_reg[idx];
    end
  endgenerate

  logic [3:0] cnt_sum;

  always_comb begin
    cnt_sum = '0;
    for (int i = 0; i < 9; i++) begin
      cnt_sum = cnt_sum + 4'(nb[i]);
    end
  end

  assign out_cnt   = cnt_sum;
  assign out_mine  = snapshot_reg[IW'(int'(row_reg) * COLS + int'(col_reg))];
  assign out_row   = row_reg;
  assign out_col   = col_reg;
  assign out_valid = (state_reg == SCAN);
  assign done      = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ms_neighbor_scan.sv
// Directed bench for ms_neighbor_scan: a padded-grid model fills a scoreboard queue
// at start, and the queue head is compared against every presented cell.
module tb_ms_neighbor_scan;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] cnt;
    logic       mine;
  } cell_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] mines = '0;
  logic         busy, done, out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   out_row, out_col, out_cnt;
  logic         out_mine;

  int checks = 0;
  int errors = 0;
  cell_t q[$];

  ms_neighbor_scan #(.COLS(16), .ROWS(16), .CB(4), .RB(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mines(mines),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_cnt(out_cnt), .out_mine(out_mine)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: zero-padded 18x18 grid so edge cells simply see empty border cells.
  task automatic fill_queue(input logic [255:0] m);
    bit grid [-1:16][-1:16];
    cell_t e;
    int s;
    for (int r = -1; r <= 16; r++)
      for (int c = -1; c <= 16; c++)
        grid[r][c] = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        grid[r][c] = m[r * 16 + c];
    q.delete();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        s = int'(grid[r-1][c-1]) + int'(grid[r-1][c]) + int'(grid[r-1][c+1]) +
            int'(grid[r][c-1])                        + int'(grid[r][c+1]) +
            int'(grid[r+1][c-1]) + int'(grid[r+1][c]) + int'(grid[r+1][c+1]);
        e.r = 4'(r);
        e.c = 4'(c);
        e.cnt = 4'(s);
        e.mine = grid[r][c];
        q.push_back(e);
      end
    end
  endtask

  task automatic run_scan(input string name, input logic [255:0] m, input int ready_pct,
                          input int abort_at, input bit mid_start);
    int accepted = 0;
    int iters = 0;
    cell_t e;
    fill_queue(m);
    @(negedge clk);
    mines = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mines = ~m;  // must not reach the frozen snapshot
    while (accepted < 256 && iters < 5000) begin
      if (abort_at >= 0 && accepted == abort_at) begin
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_abort_busy"}, 32'(busy), 32'd0);
        check({name, "_abort_valid"}, 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
          check({name, "_abort_done"}, 32'(done), 32'd0);
          @(negedge clk);
        end
        check({name, "_abort_idle"}, 32'(busy), 32'd0);
        $display("%s: reset after %0d cells, idle", name, accepted);
        q.delete();
        return;
      end
      start = mid_start && (accepted == 50);
      e = q[0];
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_done_early"}, 32'(done), 32'd0);
      check({name, "_row"}, 32'(out_row), 32'(e.r));
      check({name, "_col"}, 32'(out_col), 32'(e.c));
      check({name, "_cnt"}, 32'(out_cnt), 32'(e.cnt));
      check({name, "_mine"}, 32'(out_mine), 32'(e.mine));
      out_ready = ($urandom_range(99) < 32'(ready_pct));
      if (out_ready && out_valid) begin
        void'(q.pop_front());
        accepted++;
      end
      @(negedge clk);
      iters++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check({name, "_timeout"}, 32'(iters < 5000), 32'd1);
    check({name, "_accepted"}, 32'(accepted), 32'd256);
    if (ready_pct >= 100) check({name, "_scan_len"}, 32'(iters), 32'd256);
    check({name, "_done_pulse"}, 32'(done), 32'd1);
    check({name, "_done_busy"}, 32'(busy), 32'd1);
    check({name, "_done_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_done_once"}, 32'(done), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    $display("%s: %0d cells in %0d cycles, queue left %0d", name, accepted, iters, q.size());
  endtask

  logic [255:0] pat;

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_row", 32'(out_row), 32'd0);
    check("rst_col", 32'(out_col), 32'd0);
    check("rst_cnt", 32'(out_cnt), 32'd0);
    check("rst_mine", 32'(out_mine), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_stays_busy", 32'(busy), 32'd0);
    check("idle_stays_valid", 32'(out_valid), 32'd0);
    $display("reset: idle after 2 cycles of rst");

    run_scan("empty", '0, 100, -1, 1'b0);

    pat = '0;
    pat[5 * 16 + 5] = 1'b1;
    run_scan("centre", pat, 100, -1, 1'b0);

    pat = '0;
    pat[0] = 1'b1;
    pat[15] = 1'b1;
    run_scan("edge", pat, 100, -1, 1'b0);

    run_scan("full", '1, 100, -1, 1'b0);

    for (int i = 0; i < 8; i++) pat[i * 32 +: 32] = $urandom;
    run_scan("stall", pat, 55, -1, 1'b1);

    for (int i = 0; i < 8; i++) pat[i * 32 +: 32] = $urandom;
    run_scan("abort", pat, 70, 100, 1'b0);

    pat = '0;
    pat[15 * 16 + 14] = 1'b1;
    run_scan("recover", pat, 80, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
